// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared channel-state type and depth for the 1-to-2 registered demux
package demux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } chan_state_t;

  localparam int CHAN_DEPTH = 2;

endpackage

// File: rtl/demux_chan_buf.sv
// rtl/demux_chan_buf.sv - 2-entry per-channel buffer; slot 0 is always the head word
module demux_chan_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full
);

  chan_state_t      state_q, state_d;
  logic [WIDTH-1:0] mem_q [CHAN_DEPTH];
  logic [WIDTH-1:0] mem_d [CHAN_DEPTH];
  logic             full_q, full_d;
  logic             do_pop;

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    do_pop  = pop && (state_q != EMPTY);
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          mem_d[0] = push_data;
          state_d  = ONE;
        end
      end
      ONE: begin
        // push with pop replaces the head in place; the old head leaves this edge
        if (push && do_pop) begin
          mem_d[0] = push_data;
        end else if (push) begin
          mem_d[1] = push_data;
          state_d  = TWO;
        end else if (do_pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (do_pop) begin
          mem_d[0] = mem_q[1];
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    full_d = (state_d == TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      full_q  <= 1'b0;
      for (int i = 0; i < CHAN_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      mem_q   <= mem_d;
    end
  end

  assign head_data  = mem_q[0];
  assign head_valid = (state_q != EMPTY);
  assign full       = full_q;

endmodule

// File: rtl/demux1to2_buf.sv
// rtl/demux1to2_buf.sv - registered 1-to-2 valid/ready demux with 2-entry channel buffers
// Optional per-channel delivered-word counters cnt0/cnt1 when DEMUX_CNT_EN is defined.
module demux1to2_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  logic full0, full1;
  logic push0, push1;
  logic pop0, pop1;

  // in_ready muxes registered full flags only, so no path from outN_ready
  assign in_ready = in_sel ? ~full1 : ~full0;
  assign push0    = in_valid && in_ready && !in_sel;
  assign push1    = in_valid && in_ready && in_sel;
  assign pop0     = out0_valid && out0_ready;
  assign pop1     = out1_valid && out1_ready;

  demux_chan_buf #(.WIDTH(WIDTH)) u_chan0 (
    .clk        (clk),
    .rst        (rst),
    .push       (push0),
    .push_data  (in_data),
    .pop        (out0_ready),
    .head_data  (out0_data),
    .head_valid (out0_valid),
    .full       (full0)
  );

  demux_chan_buf #(.WIDTH(WIDTH)) u_chan1 (
    .clk        (clk),
    .rst        (rst),
    .push       (push1),
    .push_data  (in_data),
    .pop        (out1_ready),
    .head_data  (out1_data),
    .head_valid (out1_valid),
    .full       (full1)
  );

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("demux1to2_buf: CNT_W must be at least 1");
  end

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + 1'b1;
    if (pop1) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux1to2_buf.sv
// tb/tb_demux1to2_buf.sv - randomized queue-model bench for demux1to2_buf
module tb_demux1to2_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sel;
  logic       in_ready;
  logic [7:0] out0_data;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out1_data;
  logic       out1_valid;
  logic       out1_ready;
`ifdef DEMUX_CNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
`endif

  demux1to2_buf #(.WIDTH(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  always #5 clk = ~clk;

  // reference: each channel is a FIFO of at most 2 words; counters count pops mod 256
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         pops0;
  int         pops1;
  int         n_tests;
  int         n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    pops0 = 0;
    pops1 = 0;
  endtask

  // Drive one cycle at the falling edge, compare outputs, then advance the model at the rising edge.
  task automatic step(input logic v, input logic sel, input logic [7:0] d,
                      input logic r0, input logic r1);
    logic exp_ready;
    logic do_push;
    logic do_pop0;
    logic do_pop1;
    @(negedge clk);
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_ready = sel ? (q1.size() < 2) : (q0.size() < 2);
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    check("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() > 0});
    check("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() > 0});
    if (q0.size() > 0) check("out0_data", {24'd0, out0_data}, {24'd0, q0[0]});
    if (q1.size() > 0) check("out1_data", {24'd0, out1_data}, {24'd0, q1[0]});
`ifdef DEMUX_CNT_EN
    check("cnt0", {24'd0, cnt0}, pops0 % 256);
    check("cnt1", {24'd0, cnt1}, pops1 % 256);
`endif
    do_push = v && exp_ready;
    do_pop0 = r0 && (q0.size() > 0);
    do_pop1 = r1 && (q1.size() > 0);
    @(posedge clk);
    if (do_pop0) begin void'(q0.pop_front()); pops0++; end
    if (do_pop1) begin void'(q1.pop_front()); pops1++; end
    if (do_push) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check("rst_out0_data", {24'd0, out0_data}, 32'd0);
    check("rst_out1_data", {24'd0, out1_data}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = 8'h00;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // basic route
    step(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    idle(3);

    // backpressure: fill channel 0, channel 1 still accepts
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
    idle(4);

    // simultaneous push and pop in ONE
    step(1'b1, 1'b0, 8'h44, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);

    // streaming, alternating channels
    for (int i = 0; i < 16; i++) step(1'b1, i[0], 8'(8'h60 + i), 1'b1, 1'b1);
    idle(3);

    // reset with channel 1 holding two words
    step(1'b1, 1'b1, 8'hD1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'hD2, 1'b1, 1'b0);
    do_reset();
    idle(3);

    // 256 deliveries on channel 0 to wrap its counter
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
    idle(3);

    // randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      if (i == 1500) do_reset();
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
